// File: rtl/ex_stage_mdu_pkg.sv
// Shared encodings for the execute stage: aluop/alusel codes, mul/div op and FSM state enums.
package ex_stage_mdu_pkg;

  localparam int OP_W  = 8;
  localparam int SEL_W = 3;

  localparam logic [OP_W-1:0] EXE_NOP    = 8'h00;
  localparam logic [OP_W-1:0] EXE_AND    = 8'h01;
  localparam logic [OP_W-1:0] EXE_OR     = 8'h02;
  localparam logic [OP_W-1:0] EXE_XOR    = 8'h03;
  localparam logic [OP_W-1:0] EXE_SLL    = 8'h04;
  localparam logic [OP_W-1:0] EXE_SRL    = 8'h05;
  localparam logic [OP_W-1:0] EXE_SRA    = 8'h06;
  localparam logic [OP_W-1:0] EXE_ADD    = 8'h07;
  localparam logic [OP_W-1:0] EXE_SUB    = 8'h08;
  localparam logic [OP_W-1:0] EXE_SLT    = 8'h09;
  localparam logic [OP_W-1:0] EXE_SLTU   = 8'h0a;
  localparam logic [OP_W-1:0] EXE_LUI    = 8'h0b;
  localparam logic [OP_W-1:0] EXE_AUIPC  = 8'h0c;
  localparam logic [OP_W-1:0] EXE_JAL    = 8'h0d;
  localparam logic [OP_W-1:0] EXE_LW     = 8'h10;
  localparam logic [OP_W-1:0] EXE_SW     = 8'h11;
  localparam logic [OP_W-1:0] EXE_MUL    = 8'h20;
  localparam logic [OP_W-1:0] EXE_MULH   = 8'h21;
  localparam logic [OP_W-1:0] EXE_MULHSU = 8'h22;
  localparam logic [OP_W-1:0] EXE_MULHU  = 8'h23;
  localparam logic [OP_W-1:0] EXE_DIV    = 8'h24;
  localparam logic [OP_W-1:0] EXE_DIVU   = 8'h25;
  localparam logic [OP_W-1:0] EXE_REM    = 8'h26;
  localparam logic [OP_W-1:0] EXE_REMU   = 8'h27;

  localparam logic [SEL_W-1:0] EX_RES_NOP         = 3'd0;
  localparam logic [SEL_W-1:0] EX_RES_LOGIC       = 3'd1;
  localparam logic [SEL_W-1:0] EX_RES_SHIFT       = 3'd2;
  localparam logic [SEL_W-1:0] EX_RES_ARITH       = 3'd3;
  localparam logic [SEL_W-1:0] EX_RES_JUMP_BRANCH = 3'd4;
  localparam logic [SEL_W-1:0] EX_RES_LOAD_STORE  = 3'd5;
  localparam logic [SEL_W-1:0] EX_RES_MULDIV      = 3'd6;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;

  function automatic md_op_e to_md_op(input logic [OP_W-1:0] op);
    case (op)
      EXE_MULH:   return MD_MULH;
      EXE_MULHSU: return MD_MULHSU;
      EXE_MULHU:  return MD_MULHU;
      EXE_DIV:    return MD_DIV;
      EXE_DIVU:   return MD_DIVU;
      EXE_REM:    return MD_REM;
      EXE_REMU:   return MD_REMU;
      default:    return MD_MUL;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ID/EX-to-EX/MEM bundle of the execute stage; master is the pipeline side, slave the stage.
interface ex_stage_mdu_if
  import ex_stage_mdu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic             flush_i;
  logic [OP_W-1:0]  aluop_i;
  logic [SEL_W-1:0] alusel_i;
  logic [XLEN-1:0]  r1_data_i;
  logic [XLEN-1:0]  r2_data_i;
  logic             w_enable_i;
  logic [4:0]       w_addr_i;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  offset_i;
  logic [XLEN-1:0]  link_addr_i;
  logic             w_enable_o;
  logic [4:0]       w_addr_o;
  logic [XLEN-1:0]  w_data_o;
  logic [XLEN-1:0]  ram_addr_o;
  logic [OP_W-1:0]  aluop_o;
  logic             stall_req_o;

  modport master (
    output flush_i, aluop_i, alusel_i, r1_data_i, r2_data_i, w_enable_i, w_addr_i,
           pc_i, offset_i, link_addr_i,
    input  w_enable_o, w_addr_o, w_data_o, ram_addr_o, aluop_o, stall_req_o
  );

  modport slave (
    input  flush_i, aluop_i, alusel_i, r1_data_i, r2_data_i, w_enable_i, w_addr_i,
           pc_i, offset_i, link_addr_i,
    output w_enable_o, w_addr_o, w_data_o, ram_addr_o, aluop_o, stall_req_o
  );
endinterface

// File: rtl/ex_stage_mdu_muldiv_iter.sv
// Iterative M-extension unit: shift-add multiplier and restoring radix-2 divider on operand
// magnitudes, with sign fixup by negation once the iterations finish.
module ex_stage_mdu_muldiv_iter
  import ex_stage_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_BITS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  md_op_e            op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;   // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   dvs_q;   // multiplicand or divisor magnitude
  logic              neg_q, neg_r_q;

  logic              go, is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [2*XLEN:0]   mul_step, div_sh;
  logic [XLEN:0]     div_hi;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    go       = start && !flush && (state_q == S_IDLE);
    is_div   = op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    sgn_a    = op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    sgn_b    = op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    neg_a    = sgn_a && a[XLEN-1];
    neg_b    = sgn_b && b[XLEN-1];
    abs_a    = neg_a ? -a : a;
    abs_b    = neg_b ? -b : b;
    div_zero = (b == '0);
    div_ovf  = sgn_b && (a == XMIN) && (b == '1);
  end

  always_comb begin
    mul_step = {1'b0, acc_q};
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (mul_step[0])
        mul_step[2*XLEN:XLEN] = mul_step[2*XLEN:XLEN] + {1'b0, dvs_q};
      mul_step = mul_step >> 1;
    end
    div_sh = {acc_q, 1'b0};
    div_hi = div_sh[2*XLEN:XLEN];
    if (div_hi >= {1'b0, dvs_q}) begin
      div_hi    = div_hi - {1'b0, dvs_q};
      div_sh[0] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = go;
        if (go) state_d = !is_div ? S_MUL : (div_zero || div_ovf) ? S_DONE : S_DIV;
      end
      S_MUL: begin
        busy = 1'b1;
        if (cnt_q == MUL_LAST) state_d = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (cnt_q == DIV_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      busy    = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Special divides preload acc_q so the normal result path yields the architected value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= MD_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (go) begin
      op_q  <= op;
      cnt_q <= '0;
      dvs_q <= is_div ? abs_b : abs_a;
      if (is_div && div_zero) begin
        acc_q   <= {a, {XLEN{1'b1}}};
        neg_q   <= 1'b0;
        neg_r_q <= 1'b0;
      end else if (is_div && div_ovf) begin
        acc_q   <= {{XLEN{1'b0}}, XMIN};
        neg_q   <= 1'b0;
        neg_r_q <= 1'b0;
      end else begin
        acc_q   <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
        neg_q   <= neg_a ^ neg_b;
        neg_r_q <= neg_a;
      end
    end else if (state_q == S_MUL) begin
      acc_q <= mul_step[2*XLEN-1:0];
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == S_DIV) begin
      acc_q <= {div_hi[XLEN-1:0], div_sh[XLEN-1:0]};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      MD_MUL:                        result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               result = quo;
      default:                       result = rem;
    endcase
  end

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: combinational ALU/shift/compare/link/AGU plus the iterative mul/div unit,
// which holds the pipeline through stall_req_o until its result is ready.
module ex_stage_mdu
  import ex_stage_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  ex_stage_mdu_if.slave ex
);
  localparam int SH_W = $clog2(XLEN);

  logic            is_md, md_busy, md_done;
  md_op_e          md_op;
  logic [XLEN-1:0] md_result, alu_res;
  logic [SH_W-1:0] shamt;

  always_comb begin
    is_md = (ex.alusel_i == EX_RES_MULDIV);
    md_op = to_md_op(ex.aluop_i);
  end

  ex_stage_mdu_muldiv_iter #(.XLEN(XLEN), .MUL_BITS(MUL_BITS)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (is_md),
    .flush  (ex.flush_i),
    .op     (md_op),
    .a      (ex.r1_data_i),
    .b      (ex.r2_data_i),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    alu_res = '0;
    shamt   = ex.r2_data_i[SH_W-1:0];
    case (ex.alusel_i)
      EX_RES_LOGIC:
        case (ex.aluop_i)
          EXE_AND: alu_res = ex.r1_data_i & ex.r2_data_i;
          EXE_OR:  alu_res = ex.r1_data_i | ex.r2_data_i;
          EXE_XOR: alu_res = ex.r1_data_i ^ ex.r2_data_i;
          EXE_LUI: alu_res = ex.r2_data_i;
          default: alu_res = '0;
        endcase
      EX_RES_SHIFT:
        case (ex.aluop_i)
          EXE_SLL: alu_res = ex.r1_data_i << shamt;
          EXE_SRL: alu_res = ex.r1_data_i >> shamt;
          EXE_SRA: alu_res = $signed(ex.r1_data_i) >>> shamt;
          default: alu_res = '0;
        endcase
      EX_RES_ARITH:
        case (ex.aluop_i)
          EXE_ADD:   alu_res = ex.r1_data_i + ex.r2_data_i;
          EXE_SUB:   alu_res = ex.r1_data_i - ex.r2_data_i;
          EXE_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(ex.r1_data_i) < $signed(ex.r2_data_i)};
          EXE_SLTU:  alu_res = {{(XLEN-1){1'b0}}, ex.r1_data_i < ex.r2_data_i};
          EXE_AUIPC: alu_res = ex.pc_i + ex.offset_i;
          default:   alu_res = '0;
        endcase
      EX_RES_JUMP_BRANCH: alu_res = ex.link_addr_i;
      EX_RES_LOAD_STORE:  alu_res = ex.r2_data_i;
      EX_RES_MULDIV:      alu_res = md_result;
      default:            alu_res = '0;
    endcase
  end

  // Outputs are held at zero for as long as rst is asserted, independent of the inputs.
  always_comb begin
    ex.w_enable_o  = 1'b0;
    ex.w_addr_o    = '0;
    ex.w_data_o    = '0;
    ex.ram_addr_o  = '0;
    ex.aluop_o     = EXE_NOP;
    ex.stall_req_o = 1'b0;
    if (!rst) begin
      ex.w_addr_o    = ex.w_addr_i;
      ex.w_data_o    = alu_res;
      ex.w_enable_o  = ex.w_enable_i && !ex.flush_i && (!is_md || md_done);
      ex.stall_req_o = md_busy;
      if (ex.alusel_i == EX_RES_LOAD_STORE) begin
        ex.ram_addr_o = ex.r1_data_i + ex.offset_i;
        ex.aluop_o    = ex.aluop_i;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu (XLEN=32, MUL_BITS=1) with immediate-assertion checks.
module tb_ex_stage_mdu;
  import ex_stage_mdu_pkg::*;

  localparam int MD_STALLS = 32 / 1 + 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_mdu_if #(.XLEN(32)) bus ();

  ex_stage_mdu #(.XLEN(32), .MUL_BITS(1)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [SEL_W-1:0] sel, input logic [OP_W-1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bus.alusel_i  = sel;
    bus.aluop_i   = op;
    bus.r1_data_i = a;
    bus.r2_data_i = b;
  endtask

  task automatic alu_step(input logic [SEL_W-1:0] sel, input logic [OP_W-1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1 drive(sel, op, a, b);
    #1;
  endtask

  task automatic md_step(input string tag, input logic [OP_W-1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
    int   n;
    logic wen_seen;
    @(posedge clk);
    #1 drive(EX_RES_MULDIV, op, a, b);
    #1;
    n        = 0;
    wen_seen = 1'b0;
    while (bus.stall_req_o === 1'b1 && n < 200) begin
      n++;
      wen_seen = wen_seen | bus.w_enable_o;
      @(posedge clk);
      #2;
    end
    chk({tag, " stalls"}, 64'(n), 64'(exp_stalls));
    chk({tag, " wen_busy"}, {63'b0, wen_seen}, 64'd0);
    chk({tag, " data"}, {32'b0, bus.w_data_o}, {32'b0, exp});
    chk({tag, " wen"}, {63'b0, bus.w_enable_o}, 64'd1);
  endtask

  initial begin
    rst             = 1'b1;
    bus.flush_i     = 1'b0;
    bus.w_enable_i  = 1'b1;
    bus.w_addr_i    = 5'd5;
    bus.pc_i        = 32'h0000_1000;
    bus.offset_i    = 32'h0000_0004;
    bus.link_addr_i = 32'h0000_1004;
    drive(EX_RES_LOAD_STORE, EXE_LW, 32'h100, 32'h0);
    #3;
    chk("rst wen", {63'b0, bus.w_enable_o}, 64'd0);
    chk("rst ram_addr", {32'b0, bus.ram_addr_o}, 64'd0);
    chk("rst aluop", {56'b0, bus.aluop_o}, {56'b0, EXE_NOP});
    chk("rst stall", {63'b0, bus.stall_req_o}, 64'd0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("lw ram_addr", {32'b0, bus.ram_addr_o}, 64'h104);
    chk("lw aluop", {56'b0, bus.aluop_o}, {56'b0, EXE_LW});
    chk("lw w_addr", {59'b0, bus.w_addr_o}, 64'd5);

    alu_step(EX_RES_ARITH, EXE_ADD, 32'd7, 32'hFFFF_FFFD);
    chk("add", {32'b0, bus.w_data_o}, 64'h4);
    chk("add stall", {63'b0, bus.stall_req_o}, 64'd0);
    chk("add wen", {63'b0, bus.w_enable_o}, 64'd1);
    alu_step(EX_RES_SHIFT, EXE_SRA, 32'h8000_0000, 32'd4);
    chk("sra", {32'b0, bus.w_data_o}, 64'hF800_0000);
    alu_step(EX_RES_ARITH, EXE_SLTU, 32'd1, 32'hFFFF_FFFF);
    chk("sltu", {32'b0, bus.w_data_o}, 64'h1);
    chk("sltu ram_addr", {32'b0, bus.ram_addr_o}, 64'd0);
    chk("sltu aluop", {56'b0, bus.aluop_o}, {56'b0, EXE_NOP});
    alu_step(EX_RES_ARITH, EXE_SLT, 32'd1, 32'hFFFF_FFFF);
    chk("slt", {32'b0, bus.w_data_o}, 64'h0);
    bus.offset_i = 32'h20;
    alu_step(EX_RES_ARITH, EXE_AUIPC, 32'd0, 32'd0);
    chk("auipc", {32'b0, bus.w_data_o}, 64'h1020);
    alu_step(EX_RES_JUMP_BRANCH, EXE_JAL, 32'd0, 32'd0);
    chk("jal link", {32'b0, bus.w_data_o}, 64'h1004);

    md_step("mul", EXE_MUL, 32'h1234, 32'h5678, 32'h0626_0060, MD_STALLS);
    md_step("mulhsu", EXE_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD_STALLS);
    md_step("mulhu", EXE_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MD_STALLS);
    md_step("mulh", EXE_MULH, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, MD_STALLS);
    md_step("div", EXE_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, MD_STALLS);
    md_step("rem", EXE_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, MD_STALLS);
    md_step("divu0", EXE_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    md_step("remu0", EXE_REMU, 32'd5, 32'd0, 32'h5, 1);
    md_step("div ovf", EXE_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    md_step("rem ovf", EXE_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    md_step("divu x0", EXE_DIVU, 32'd0, 32'd3, 32'h0, MD_STALLS);

    // Flush ten cycles into a divide, then flush coinciding with a fresh start.
    @(posedge clk);
    #1 drive(EX_RES_MULDIV, EXE_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    #1;
    chk("flush stall", {63'b0, bus.stall_req_o}, 64'd0);
    chk("flush wen", {63'b0, bus.w_enable_o}, 64'd0);
    @(posedge clk);
    #2;
    chk("flush+start stall", {63'b0, bus.stall_req_o}, 64'd0);
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    drive(EX_RES_ARITH, EXE_ADD, 32'd2, 32'd3);
    #1;
    chk("post-flush stall", {63'b0, bus.stall_req_o}, 64'd0);
    chk("post-flush add", {32'b0, bus.w_data_o}, 64'h5);

    // Reset pulse in the middle of a divide.
    @(posedge clk);
    #1 drive(EX_RES_MULDIV, EXE_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid-rst stall", {63'b0, bus.stall_req_o}, 64'd0);
    chk("mid-rst data", {32'b0, bus.w_data_o}, 64'd0);
    chk("mid-rst wen", {63'b0, bus.w_enable_o}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(EX_RES_ARITH, EXE_ADD, 32'd10, 32'd20);
    #1;
    chk("post-rst add", {32'b0, bus.w_data_o}, 64'd30);
    chk("post-rst stall", {63'b0, bus.stall_req_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
